// File: rtl/priority_encoder_case_sync.sv
// Registered priority encoder: reports the index of the highest set request bit,
// a request-present flag, and the request vector masked down to its winning bit.
module priority_encoder_case_sync #(
  parameter  int WIDTH = 4,
  localparam int OUT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] Y,
  output logic [OUT_W-1:0] A,
  output logic             valid,
  output logic [WIDTH-1:0] onehot
);

  logic [OUT_W-1:0] idx_c;
  logic             hit_c;
  logic [WIDTH-1:0] onehot_c;

  generate
    if (WIDTH == 4) begin : g_case4
      always_comb begin
        idx_c = '0;
        hit_c = 1'b0;
        casez (Y)
          4'b1???: begin idx_c = 2'd3; hit_c = 1'b1; end
          4'b01??: begin idx_c = 2'd2; hit_c = 1'b1; end
          4'b001?: begin idx_c = 2'd1; hit_c = 1'b1; end
          4'b0001: begin idx_c = 2'd0; hit_c = 1'b1; end
          default: begin idx_c = 2'd0; hit_c = 1'b0; end
        endcase
      end
    end else begin : g_scan
      // MSB-first scan; the first hit locks out every lower bit.
      always_comb begin
        idx_c = '0;
        hit_c = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
          if (!hit_c && Y[i]) begin
            hit_c = 1'b1;
            idx_c = OUT_W'(i);
          end
        end
      end
    end
  endgenerate

  always_comb begin
    onehot_c = '0;
    if (hit_c) onehot_c = WIDTH'(1) << idx_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      A      <= '0;
      valid  <= 1'b0;
      onehot <= '0;
    end else if (en) begin
      A      <= idx_c;
      valid  <= hit_c;
      onehot <= onehot_c;
    end
  end

endmodule

// File: tb/tb_priority_encoder_case_sync.sv
// Bench for priority_encoder_case_sync: directed plus random stimulus, a queue of
// expected outputs from an arithmetic reference model, and an independent monitor.
module tb_priority_encoder_case_sync;

  localparam int WIDTH = 4;
  localparam int OUT_W = 2;

  typedef struct {
    logic [OUT_W-1:0] a;
    logic             v;
    logic [WIDTH-1:0] oh;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en  = 1'b0;
  logic [WIDTH-1:0] y   = '0;
  logic [OUT_W-1:0] a;
  logic             valid;
  logic [WIDTH-1:0] onehot;

  int n_vec = 0;
  int n_bad = 0;
  exp_t sb_q[$];

  // reference state: what the outputs should be after the most recent edge
  exp_t mdl;

  priority_encoder_case_sync #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .Y      (y),
    .A      (a),
    .valid  (valid),
    .onehot (onehot)
  );

  always #5 clk = ~clk;

  // highest set bit via log2 arithmetic rather than a bit scan
  function automatic exp_t ref_encode(input logic [WIDTH-1:0] v);
    exp_t e;
    int   val;
    int   idx;
    val = int'(v);
    if (val == 0) begin
      e.a  = '0;
      e.v  = 1'b0;
      e.oh = '0;
    end else begin
      idx  = $clog2(val + 1) - 1;
      e.a  = OUT_W'(idx);
      e.v  = 1'b1;
      e.oh = WIDTH'(1 << idx);
    end
    return e;
  endfunction

  task automatic step(input logic r, input logic e, input logic [WIDTH-1:0] v);
    @(negedge clk);
    rst = r;
    en  = e;
    y   = v;
    @(posedge clk);
    if (r) begin
      mdl.a  = '0;
      mdl.v  = 1'b0;
      mdl.oh = '0;
    end else if (e) begin
      mdl = ref_encode(v);
    end
    sb_q.push_back(mdl);
  endtask

  // monitor: the DUT presents a registered result after every edge
  always @(posedge clk) begin
    exp_t ex;
    #1;
    if (sb_q.size() > 0) begin
      ex = sb_q.pop_front();
      n_vec++;
      if (a !== ex.a || valid !== ex.v || onehot !== ex.oh) begin
        n_bad++;
        $display("FAIL encode t=%0t: got A=%b valid=%b onehot=%b, want A=%b valid=%b onehot=%b",
                 $time, a, valid, onehot, ex.a, ex.v, ex.oh);
      end
    end
  end

  initial begin
    mdl.a  = '0;
    mdl.v  = 1'b0;
    mdl.oh = '0;

    // reset dominates en with all requests high
    step(1'b1, 1'b1, 4'b1111);
    step(1'b1, 1'b1, 4'b1111);
    step(1'b0, 1'b1, 4'b1111);

    // single-bit sweep
    step(1'b0, 1'b1, 4'b0000);
    step(1'b0, 1'b1, 4'b0001);
    step(1'b0, 1'b1, 4'b0010);
    step(1'b0, 1'b1, 4'b0100);
    step(1'b0, 1'b1, 4'b1000);

    // multi-bit priority
    step(1'b0, 1'b1, 4'b1100);
    step(1'b0, 1'b1, 4'b0110);
    step(1'b0, 1'b1, 4'b1010);
    step(1'b0, 1'b1, 4'b0011);

    // enable hold
    step(1'b0, 1'b1, 4'b0100);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 4'b1000);
    step(1'b0, 1'b1, 4'b1000);

    // reset mid-stream, then resume from current Y
    step(1'b1, 1'b1, 4'b1000);
    step(1'b0, 1'b1, 4'b1000);
    step(1'b0, 1'b1, 4'b0101);

    // exhaustive
    for (int k = 0; k < 16; k++) step(1'b0, 1'b1, WIDTH'(k));

    // random mix of enable, occasional reset, and request patterns
    for (int k = 0; k < 300; k++)
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), WIDTH'($urandom));

    @(negedge clk);
    en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
